bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_control.sv | 18 +
 rtl/bus_responder.sv | 104 ++++++++++
 tb/tb_bus_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and default widths for the bus responder slice.
package bus_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_ACK     = 3'd1,
    RD_TURN    = 3'd2,
    RD_DRIVE   = 3'd3,
    RD_RELEASE = 3'd4
  } state_e;

  // States in which a completion pulse is presented to the initiator.
  function automatic logic state_acks(input state_e s);
    return (s == WR_ACK) || (s == RD_DRIVE);
  endfunction

endpackage

// File: rtl/bus_control.sv
// Tri-state bus driver: drives data_tx onto the bus when ctrl_signal is high,
// and always returns the resolved bus value on data_rx.
module bus_control
  import bus_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF
) (
  input  logic             ctrl_signal,
  input  logic [WIDTH-1:0] data_tx,
  output logic [WIDTH-1:0] data_rx,
  inout  wire  [WIDTH-1:0] bus
);

  // Drive only when enabled; otherwise leave the bus floating for others.
  assign bus     = ctrl_signal ? data_tx : {WIDTH{1'bz}};
  assign data_rx = bus;

endmodule

// File: rtl/bus_responder.sv
// Single-port memory target on a shared bidirectional bus. Writes complete
// in one cycle; reads insert a turnaround cycle before and after driving.
module bus_responder
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_sel,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_ack,
  output logic                  busy,
  output logic                  drive_en,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    ack_q, busy_q, drive_q;
  logic                    wr_en_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [DATA_WIDTH-1:0]   wr_word_s;

  // Next-state and request decode; strobes are only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_sel) begin
          if (bus_we) begin
            wr_en_s = 1'b1;
            state_d = WR_ACK;
          end else begin
            addr_d  = bus_addr;
            state_d = RD_TURN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ACK:     state_d = IDLE;
      RD_TURN:    state_d = RD_DRIVE;
      RD_DRIVE:   state_d = RD_RELEASE;
      RD_RELEASE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State, read address latch and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= state_acks(state_d);
      busy_q  <= (state_d != IDLE);
      drive_q <= (state_d == RD_DRIVE);
    end
  end

  // Storage array; cleared by reset, written on an accepted write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[bus_addr] <= wr_word_s;
    end
  end

  // Writes are impossible during a read, so the addressed word is stable
  // for the whole read and can be presented directly.
  assign rd_word_s = mem_q[addr_q];

  bus_control #(
    .WIDTH(DATA_WIDTH)
  ) u_bus_control (
    .ctrl_signal(drive_q),
    .data_tx    (rd_word_s),
    .data_rx    (wr_word_s),
    .bus        (bus_data)
  );

  assign bus_ack   = ack_q;
  assign busy      = busy_q;
  assign drive_en  = drive_q;
  assign collision = bus_sel & busy_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios plus random
// traffic, checked every cycle against a transaction-level timeline model.
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_sel = 1'b0;
  logic       bus_we = 1'b0;
  logic [4:0] bus_addr = 5'd0;
  wire  [7:0] bus_data;
  logic       bus_ack, busy, drive_en, collision;

  logic       tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h00;
  assign bus_data = tb_drv ? tb_val : 8'bz;

  bus_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_ack(bus_ack),
    .busy(busy), .drive_en(drive_en), .collision(collision)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model: which cycle the responder is next free, when its ack
  // and read data are due, and the word a pending read will return.
  logic [7:0] mem_m [32];
  int         cyc = 0;
  int         free_at = 0;
  int         ack_at = -10;
  int         drive_at = -10;
  logic [7:0] rd_val = 8'h00;
  int         n_acc = 0;
  int         ack_seen = 0;

  logic       chk_en = 1'b0;
  logic       exp_busy, exp_ack, exp_drive, exp_coll;
  logic [7:0] exp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
    free_at  = 0;
    ack_at   = -10;
    drive_at = -10;
    rd_val   = 8'h00;
  endtask

  // One bus cycle: apply inputs just after the rising edge, predict the
  // outputs for this cycle, then advance the model by the accepted strobe.
  task automatic step(input logic s, input logic w, input logic [4:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cyc++;
    exp_busy  = (cyc < free_at);
    exp_ack   = (cyc == ack_at);
    exp_drive = (cyc == drive_at);
    exp_data  = rd_val;
    exp_coll  = s && exp_busy;
    bus_sel  = s;
    bus_we   = w;
    bus_addr = a;
    tb_val   = d;
    tb_drv   = s && w && !exp_drive;
    if (s && !exp_busy) begin
      n_acc++;
      if (w) begin
        mem_m[a] = d;
        ack_at   = cyc + 1;
        free_at  = cyc + 2;
      end else begin
        rd_val   = mem_m[a];
        ack_at   = cyc + 2;
        drive_at = cyc + 2;
        free_at  = cyc + 4;
      end
    end
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic read_check(input logic [4:0] a, input logic [7:0] e, input string name);
    step(1'b1, 1'b0, a, 8'h00);
    idle();
    idle();
    chk(name, bus_data, e);
    chk({name, "_drive"}, drive_en, 1'b1);
    idle();
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    bus_sel = 1'b0;
    bus_we  = 1'b0;
    tb_drv  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", bus_ack, 1'b0);
    chk("rst_drive", drive_en, 1'b0);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("busy", busy, exp_busy);
      chk("ack", bus_ack, exp_ack);
      chk("drive_en", drive_en, exp_drive);
      chk("collision", collision, exp_coll);
      if (exp_drive) chk("bus_data", bus_data, exp_data);
      if (bus_ack) ack_seen++;
    end
  end

  initial begin
    int acc0, ack0;
    logic [31:0] r;

    // Reset state and read of a cleared word.
    do_reset();
    read_check(5'd7, 8'h00, "rd7_after_reset");

    // Write then read with exact latencies.
    step(1'b1, 1'b1, 5'd3, 8'hA5);
    idle();
    chk("wr_ack_n1", bus_ack, 1'b1);
    step(1'b1, 1'b0, 5'd3, 8'h00);
    idle();
    chk("turn_no_drive", drive_en, 1'b0);
    chk("turn_no_ack", bus_ack, 1'b0);
    idle();
    chk("rd3_data", bus_data, 8'hA5);
    chk("rd3_ack", bus_ack, 1'b1);
    idle();
    chk("release_no_drive", drive_en, 1'b0);
    idle();

    // Boundary addresses and untouched neighbours.
    step(1'b1, 1'b1, 5'd0, 8'h11);
    idle();
    step(1'b1, 1'b1, 5'd31, 8'hEE);
    idle();
    read_check(5'd0, 8'h11, "rd_addr0");
    read_check(5'd31, 8'hEE, "rd_addr31");
    read_check(5'd1, 8'h00, "rd_addr1");
    read_check(5'd30, 8'h00, "rd_addr30");
    read_check(5'd3, 8'hA5, "rd_addr3_kept");

    // Write into an in-flight read is rejected.
    step(1'b1, 1'b1, 5'd5, 8'h5A);
    idle();
    step(1'b1, 1'b0, 5'd5, 8'h00);
    step(1'b1, 1'b1, 5'd5, 8'hFF);
    chk("coll_pulse", collision, 1'b1);
    idle();
    chk("coll_rd_old", bus_data, 8'h5A);
    idle();
    read_check(5'd5, 8'h5A, "coll_later_rd");

    // Reset asserted while the read word is on the bus.
    step(1'b1, 1'b0, 5'd3, 8'h00);
    idle();
    @(posedge clk);
    #1;
    chk_en  = 1'b0;
    bus_sel = 1'b0;
    #2;
    chk("pre_rst_drive", drive_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_drive", drive_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ack", bus_ack, 1'b0);
    tb_val = 8'h96;
    tb_drv = 1'b1;
    #1;
    chk("mid_rst_bus_free", bus_data, 8'h96);
    tb_drv = 1'b0;
    do_reset();
    // First edge after release accepts a strobe.
    step(1'b1, 1'b1, 5'd2, 8'h77);
    idle();
    chk("post_rst_ack", bus_ack, 1'b1);
    read_check(5'd3, 8'h00, "rd3_cleared");

    // Back-to-back strobes every cycle.
    ack0 = ack_seen;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 2) == 0, 5'd9, 8'h3C);
    end
    repeat (4) idle();
    chk("b2b_ack_count", ack_seen - ack0, 4);
    read_check(5'd9, 8'h3C, "b2b_rd9");

    // Random traffic against the model.
    acc0 = n_acc;
    ack0 = ack_seen;
    for (int i = 0; i < 800; i++) begin
      r = $urandom();
      step(r[0] | r[1], r[2], r[7:3], r[15:8]);
    end
    repeat (5) idle();
    chk("rand_ack_per_accept", ack_seen - ack0, n_acc - acc0);
    for (int a = 0; a < 32; a++) begin
      read_check(a[4:0], mem_m[a], "final_sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
